// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_ctrl
// Description : Valid/ready front end that sequences single read/write ops
//               onto a strobe-driven SRAM with fixed setup/pulse/hold timing.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_ctrl #(
   parameter int ADDR_W     = 4,
   parameter int DATA_W     = 8,
   parameter int SETUP_CYC  = 1,
   parameter int STROBE_CYC = 2,
   parameter int HOLD_CYC   = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_read,
   output logic              mem_write,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   localparam int c_MAX_SH  = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
   localparam int c_MAX_CYC = (STROBE_CYC > c_MAX_SH) ? STROBE_CYC : c_MAX_SH;
   localparam int c_CNT_W   = $clog2(c_MAX_CYC + 1);

   // Counter is preloaded with phase length - 1 and counts down to zero
   localparam logic [c_CNT_W-1:0] c_SETUP_LD  = c_CNT_W'(SETUP_CYC - 1);
   localparam logic [c_CNT_W-1:0] c_STROBE_LD = c_CNT_W'(STROBE_CYC - 1);
   localparam logic [c_CNT_W-1:0] c_HOLD_LD   = c_CNT_W'(HOLD_CYC - 1);
   localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETUP  = 3'd1,
      ST_STROBE = 3'd2,
      ST_HOLD   = 3'd3,
      ST_RESP   = 3'd4
   } state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic [c_CNT_W-1:0]  r_cnt;
   logic [c_CNT_W-1:0]  w_cnt_next;
   logic                w_accept;
   logic                w_capture;
   logic                r_op_we;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic [DATA_W-1:0]   r_mem_wdata;
   logic                r_mem_read;
   logic                r_mem_write;
   logic [DATA_W-1:0]   r_rsp_rdata;

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_accept     = 1'b0;
      w_capture    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (req_valid) begin
               w_accept     = 1'b1;
               w_state_next = ST_SETUP;
               w_cnt_next   = c_SETUP_LD;
            end
         end
         ST_SETUP: begin
            if (r_cnt == '0) begin
               w_state_next = ST_STROBE;
               w_cnt_next   = c_STROBE_LD;
            end else begin
               w_cnt_next   = r_cnt - c_CNT_ONE;
            end
         end
         ST_STROBE: begin
            if (r_cnt == '0) begin
               w_state_next = ST_HOLD;
               w_cnt_next   = c_HOLD_LD;
            end else begin
               w_cnt_next   = r_cnt - c_CNT_ONE;
            end
         end
         ST_HOLD: begin
            if (r_cnt == '0) begin
               w_state_next = r_op_we ? ST_IDLE : ST_RESP;
               w_capture    = ~r_op_we;
               w_cnt_next   = '0;
            end else begin
               w_cnt_next   = r_cnt - c_CNT_ONE;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               w_state_next = ST_IDLE;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
            w_cnt_next   = '0;
         end
      endcase
   end

   // Strobes are decoded from the next state so they leave a flop cleanly
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_op_we     <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_mem_read  <= 1'b0;
         r_mem_write <= 1'b0;
         r_rsp_rdata <= '0;
      end else begin
         r_state     <= w_state_next;
         r_cnt       <= w_cnt_next;
         r_mem_read  <= (w_state_next == ST_STROBE) && !r_op_we;
         r_mem_write <= (w_state_next == ST_STROBE) &&  r_op_we;
         if (w_accept) begin
            r_op_we     <= req_we;
            r_mem_addr  <= req_addr;
            r_mem_wdata <= req_wdata;
         end
         if (w_capture) begin
            r_rsp_rdata <= mem_rdata;
         end
      end
   end

   assign req_ready = (r_state == ST_IDLE);
   assign busy      = (r_state != ST_IDLE);
   assign rsp_valid = (r_state == ST_RESP);
   assign rsp_rdata = r_rsp_rdata;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign mem_read  = r_mem_read;
   assign mem_write = r_mem_write;

endmodule
`default_nettype wire
